io_port_bank: RTL

//   Multi-channel successor to the single-port IN/OUT unit. Sits beside the MEM stage and serves
//   the OUT/IN instructions over NUM_CH output and NUM_CH input channels plus one status word.

---
 rtl/io_port_bank.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// ============================================================================
// io_port_bank
// ----------------------------------------------------------------------------
// Multi-channel I/O port bank serving the OUT/IN instructions beside the MEM
// stage. It provides NUM_CH output channels, NUM_CH input channels and one
// status word, all reached through a single shared channel address.
//
// Output channels hold sticky data. A write raises a pending flag that stays
// set until the external device acknowledges it. Writing a channel that is
// still pending overwrites its data and sets that channel's overflow flag.
//
// Input channels take an asynchronous level strobe from the device. The
// strobe passes through a synchroniser chain and then an edge-detect flop.
// A rising edge captures the channel data and sets its valid flag, which
// stays set until software reads that channel.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active-high
//   we           OUT write enable
//   re           IN read enable
//   addr         0..NUM_CH-1 selects a channel, NUM_CH selects the status word
//   data_i       OUT write data
//   data_o       IN read data (combinational, zero when nothing is read)
//   out_data_o   output channel registers, channel k at [k*DATA_W +: DATA_W]
//   out_pend_o   per-channel "holds un-acked data" flags
//   out_ack_i    per-channel single-cycle consume pulse from the device
//   in_data_i    input channel data, same packing as out_data_o
//   in_strobe_i  per-channel asynchronous "data ready" level from the device
//   irq_o        high while any input channel holds unread data
//
// Status word layout (N = NUM_CH)
//   [N-1:0]    in_valid
//   [2N-1:N]   out_pend
//   [3N-1:2N]  in_ovf
//   [4N-1:3N]  out_ovf
//   upper bits read as zero
// ============================================================================
module io_port_bank #(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [NUM_CH*DATA_W-1:0] out_data_o,
    output logic [NUM_CH-1:0]        out_pend_o,
    input  logic [NUM_CH-1:0]        out_ack_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    input  logic [NUM_CH-1:0]        in_strobe_i,
    output logic                     irq_o
);

    // The status word sits at the first address past the last channel.
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_CH);

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0][DATA_W-1:0]      outData_q, outData_d;
    logic [NUM_CH-1:0]                  outPend_q, outPend_d;
    logic [NUM_CH-1:0]                  outOvf_q,  outOvf_d;

    logic [NUM_CH-1:0][DATA_W-1:0]      inCap_q,   inCap_d;
    logic [NUM_CH-1:0]                  inValid_q, inValid_d;
    logic [NUM_CH-1:0]                  inOvf_q,   inOvf_d;

    logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q,    sync_d;
    logic [NUM_CH-1:0]                  strobeDly_q, strobeDly_d;

    // ------------------------------------------------------------------------
    // Decoded access strobes
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] wrSel;
    logic [NUM_CH-1:0] rdSel;
    logic              statusRd;
    logic [NUM_CH-1:0] strobeRise;
    logic [DATA_W-1:0] statusWord;

    // Turn the shared address into one-hot channel selects for the write and
    // read paths. Addresses beyond the channel range select nothing, which
    // is what makes out-of-range writes and reads side-effect free.
    always_comb begin
        wrSel = '0;
        rdSel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wrSel[k] = we && (addr == ADDR_W'(k));
            rdSel[k] = re && (addr == ADDR_W'(k));
        end
        statusRd = re && (addr == STATUS_ADDR);
    end

    // ------------------------------------------------------------------------
    // Input strobe synchronisers and edge detection
    // ------------------------------------------------------------------------
    // Each strobe shifts into its own synchroniser chain; the oldest stage
    // feeds one extra flop so a rising edge is seen as "last stage high,
    // delay flop still low". Capture therefore lands SYNC_STAGES+1 edges
    // after the device raises its strobe.
    always_comb begin
        sync_d      = sync_q;
        strobeDly_d = strobeDly_q;
        strobeRise  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sync_d[k]      = {sync_q[k][SYNC_STAGES-2:0], in_strobe_i[k]};
            strobeDly_d[k] = sync_q[k][SYNC_STAGES-1];
            strobeRise[k]  = sync_q[k][SYNC_STAGES-1] & ~strobeDly_q[k];
        end
    end

    // ------------------------------------------------------------------------
    // Output channel next state
    // ------------------------------------------------------------------------
    // A write always loads data and leaves the channel pending, even when the
    // device acks in the same cycle: the ack consumed the old value, the new
    // one is still waiting. Overflow only marks a write that replaced data
    // the device never acknowledged. A status read clears the overflow
    // vector, but an overflow raised in that same cycle survives the clear.
    always_comb begin
        outData_d = outData_q;
        outPend_d = outPend_q;
        outOvf_d  = outOvf_q;
        if (statusRd) begin
            outOvf_d = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (wrSel[k]) begin
                outData_d[k] = data_i;
                outPend_d[k] = 1'b1;
                if (outPend_q[k] && !out_ack_i[k]) begin
                    outOvf_d[k] = 1'b1;
                end
            end else if (out_ack_i[k]) begin
                outPend_d[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Input channel next state
    // ------------------------------------------------------------------------
    // A fresh capture takes priority over a read of the same channel, so data
    // that arrives while software is reading the old value is never lost.
    // Overflow marks a capture that replaced data nobody read; a read in the
    // same cycle means the old value was consumed, so it is not an overflow.
    always_comb begin
        inCap_d   = inCap_q;
        inValid_d = inValid_q;
        inOvf_d   = inOvf_q;
        if (statusRd) begin
            inOvf_d = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (strobeRise[k]) begin
                inCap_d[k]   = in_data_i[k*DATA_W +: DATA_W];
                inValid_d[k] = 1'b1;
                if (inValid_q[k] && !rdSel[k]) begin
                    inOvf_d[k] = 1'b1;
                end
            end else if (rdSel[k]) begin
                inValid_d[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // Reset clears every flag, capture register and synchroniser stage at
    // once, so a strobe that was part-way through the chain is forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outData_q   <= '0;
            outPend_q   <= '0;
            outOvf_q    <= '0;
            inCap_q     <= '0;
            inValid_q   <= '0;
            inOvf_q     <= '0;
            sync_q      <= '0;
            strobeDly_q <= '0;
        end else begin
            outData_q   <= outData_d;
            outPend_q   <= outPend_d;
            outOvf_q    <= outOvf_d;
            inCap_q     <= inCap_d;
            inValid_q   <= inValid_d;
            inOvf_q     <= inOvf_d;
            sync_q      <= sync_d;
            strobeDly_q <= strobeDly_d;
        end
    end

    // ------------------------------------------------------------------------
    // Status word assembly
    // ------------------------------------------------------------------------
    always_comb begin
        statusWord                         = '0;
        statusWord[NUM_CH-1:0]             = inValid_q;
        statusWord[2*NUM_CH-1:NUM_CH]      = outPend_q;
        statusWord[3*NUM_CH-1:2*NUM_CH]    = inOvf_q;
        statusWord[4*NUM_CH-1:3*NUM_CH]    = outOvf_q;
    end

    // ------------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------------
    // The bus reads zero unless a read is active and hits either a channel
    // or the status word; unused addresses also read zero.
    always_comb begin
        data_o = '0;
        if (re) begin
            if (addr == STATUS_ADDR) begin
                data_o = statusWord;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (addr == ADDR_W'(k)) begin
                        data_o = inCap_q[k];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Device-facing outputs
    // ------------------------------------------------------------------------
    assign out_data_o = outData_q;
    assign out_pend_o = outPend_q;
    assign irq_o      = |inValid_q;

endmodule
